// File: rtl/spike_rect_if.sv
// rtl/spike_rect_if.sv - request and pixel-stream bundle for spike_rect_drawer
interface spike_rect_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                go;
    logic [X_W-1:0]      org_x;
    logic [Y_W-1:0]      org_y;
    logic [X_W-1:0]      rect_w;
    logic [Y_W-1:0]      rect_h;
    logic [COLOUR_W-1:0] colour_in;
    logic                spike_mode;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output go, org_x, org_y, rect_w, rect_h, colour_in, spike_mode,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  go, org_x, org_y, rect_w, rect_h, colour_in, spike_mode,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/spike_rect_drawer.sv
// rtl/spike_rect_drawer.sv - rectangle pixel-stream generator, spike mask under SPIKE_RECT_SPIKE_MASK_EN
module spike_rect_drawer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int TOOTH_W  = 8
) (
    input  logic       clock,
    input  logic       resetn,
    spike_rect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t              state;
    logic [X_W-1:0]      ox, rw, cx;
    logic [Y_W-1:0]      oy, rh, cy;
    logic [COLOUR_W-1:0] col;
    logic                smode;
    logic                mask;

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q, busy_q, done_q;

`ifdef SPIKE_RECT_SPIKE_MASK_EN
    localparam int TP_W = $clog2(TOOTH_W);
    logic [TP_W-1:0] p, d;

    // Distance to the nearer tooth edge; tips sit at row 0, solid from row h-1 down.
    assign p    = cx[TP_W-1:0];
    assign d    = (p < TP_W'(TOOTH_W / 2)) ? p : (TP_W'(TOOTH_W - 1) - p);
    assign mask = !smode || (({1'b0, cy} + (Y_W + 1)'(d)) >= (Y_W + 1)'(TOOTH_W / 2 - 1));
`else
    logic unused_spike_mode;
    assign unused_spike_mode = bus.spike_mode ^ smode;
    assign mask              = 1'b1;
`endif

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // Status outputs trail the state by one edge so they line up with the registered pixel stream.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            ox       <= '0;
            oy       <= '0;
            rw       <= '0;
            rh       <= '0;
            col      <= '0;
            smode    <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state != IDLE);
            done_q <= (state == DONE);
            plot_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        ox    <= bus.org_x;
                        oy    <= bus.org_y;
                        rw    <= bus.rect_w;
                        rh    <= bus.rect_h;
                        col   <= bus.colour_in;
`ifdef SPIKE_RECT_SPIKE_MASK_EN
                        smode <= bus.spike_mode;
`endif
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cx    <= '0;
                    cy    <= '0;
                    state <= (rw == '0 || rh == '0) ? DONE : DRAW;
                end
                DRAW: begin
                    x_q      <= ox + cx;
                    y_q      <= oy + cy;
                    colour_q <= col;
                    plot_q   <= mask;
                    if (cx == rw - X_W'(1)) begin
                        cx <= '0;
                        cy <= cy + Y_W'(1);
                        if (cy == rh - Y_W'(1))
                            state <= DONE;
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_rect_drawer.sv
// tb/tb_spike_rect_drawer.sv - directed self-checking bench for spike_rect_drawer
module tb_spike_rect_drawer;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   failed = 0;

    spike_rect_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    spike_rect_drawer #(.X_W(8), .Y_W(7), .COLOUR_W(3), .TOOTH_W(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_mask(input int cx, input int cy, input int sm);
`ifdef SPIKE_RECT_SPIKE_MASK_EN
        int p, d;
        p = cx % 8;
        d = (p < 7 - p) ? p : 7 - p;
        return (sm == 0) || (cy + d >= 3);
`else
        return 1'b1;
`endif
    endfunction

    // One go pulse, then every cycle through the gap after done is checked against the model.
    task automatic run_rect(input int ox, input int oy, input int w, input int h,
                            input int col, input int sm);
        int n, i, cx, cy;
        n = w * h;
        bus.org_x      = 8'(ox);
        bus.org_y      = 7'(oy);
        bus.rect_w     = 8'(w);
        bus.rect_h     = 7'(h);
        bus.colour_in  = 3'(col);
        bus.spike_mode = sm[0];
        bus.go         = 1'b1;
        step();
        bus.go        = 1'b0;
        bus.org_x     = 8'(ox + 77);
        bus.org_y     = 7'(oy + 33);
        bus.rect_w    = 8'(w + 1);
        bus.rect_h    = 7'(h + 2);
        bus.colour_in = 3'(col + 1);
        for (int k = 1; k <= n + 3; k++) begin
            step();
            chk("busy", bus.busy, 32'(k <= n + 2));
            chk("done", bus.done, 32'(k == n + 2));
            if (k >= 2 && k <= n + 1) begin
                i  = k - 2;
                cx = i % w;
                cy = i / w;
                chk("plot", bus.plot, 32'(model_mask(cx, cy, sm)));
                chk("x", bus.x, 32'((ox + cx) % 256));
                chk("y", bus.y, 32'((oy + cy) % 128));
                chk("colour", bus.colour, 32'(col));
            end else begin
                chk("plot_idle", bus.plot, 32'd0);
            end
        end
    endtask

    initial begin
        bus.go = 1'b0;
        bus.org_x = '0; bus.org_y = '0; bus.rect_w = '0; bus.rect_h = '0;
        bus.colour_in = '0; bus.spike_mode = 1'b0;
        step();
        step();
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        resetn = 1'b1;
        step();

        run_rect(10, 5, 3, 2, 5, 0);
        chk("hold_x", bus.x, 12);
        chk("hold_y", bus.y, 6);
        run_rect(20, 3, 0, 4, 2, 0);
        run_rect(254, 126, 3, 3, 6, 0);
        run_rect(7, 9, 1, 1, 7, 1);

        // Abort a 160x20 fill mid-draw.
        bus.org_x = 8'd0; bus.org_y = 7'd0; bus.rect_w = 8'd160; bus.rect_h = 7'd20;
        bus.colour_in = 3'd4; bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int k = 0; k < 50; k++) step();
        chk("pre_rst_plot", bus.plot, 1);
        resetn = 1'b0;
        step();
        chk("mid_rst_x", bus.x, 0);
        chk("mid_rst_y", bus.y, 0);
        chk("mid_rst_colour", bus.colour, 0);
        chk("mid_rst_plot", bus.plot, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        step();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_busy", bus.busy, 0);
            chk("post_rst_plot", bus.plot, 0);
            chk("post_rst_done", bus.done, 0);
        end
        run_rect(0, 0, 160, 20, 4, 0);

        // go held high: second 2x2 draw restarts only from IDLE.
        bus.org_x = 8'd40; bus.org_y = 7'd50; bus.rect_w = 8'd2; bus.rect_h = 7'd2;
        bus.colour_in = 3'd3; bus.go = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 8) bus.go = 1'b0;
            chk("hs_busy", bus.busy, 32'((k <= 6) || (k >= 8 && k <= 13)));
            chk("hs_done", bus.done, 32'(k == 6 || k == 13));
            chk("hs_plot", bus.plot, 32'((k >= 2 && k <= 5) || (k >= 9 && k <= 12)));
            if (k == 9) begin
                chk("hs_restart_x", bus.x, 40);
                chk("hs_restart_y", bus.y, 50);
            end
        end

`ifdef SPIKE_RECT_SPIKE_MASK_EN
        run_rect(30, 10, 16, 4, 1, 1);
        run_rect(30, 10, 16, 4, 2, 0);
`else
        run_rect(30, 10, 16, 4, 1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
